// File: rtl/mac_tx_framer_if.sv
// mac_tx_framer_if: payload byte stream feeding the transmit framer.
// The source drives data/last/valid; the framer returns ready.
interface mac_tx_framer_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: Ethernet II GMII transmit framer with pad and inline FCS.
// Define MAC_VLAN_EN to enable 802.1Q tag insertion after the source MAC.
module mac_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int IFG_BYTES    = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [47:0]    des_mac_addr,
    input  logic [47:0]    src_mac_addr,
    input  logic [15:0]    prot_type,
`ifdef MAC_VLAN_EN
    input  logic           vlan_insert,
    input  logic [15:0]    vlan_tag,
`endif
    mac_tx_framer_if.slave s_if,
    output logic           tx_en,
    output logic [7:0]     txd,
    output logic           tx_er,
    output logic           tx_busy,
    output logic           frame_done,
    output logic           frame_abort
);

    typedef enum logic [3:0] {
        IDLE, PRE, SFD, HDR, PAY, PAD, FCS, IFG, DRAIN
    } state_t;

    localparam logic [10:0] PRE_END = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0] MIN_L   = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_L   = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_END = 11'(IFG_BYTES - 2);
    // The IDLE cycle before the next preamble counts as one gap byte
    localparam state_t      GAP     = (IFG_BYTES > 1) ? IFG : IDLE;

    state_t         state_q, state_d;
    logic [10:0]    cnt_q, cnt_d, cnt_nx;
    logic [143:0]   hdr_q, hdr_d, hdr_in;
    logic           vlan_q, vlan_d, vlan_in;
    logic [31:0]    crc_q, fcs_w;
    logic [7:0]     txd_q, txd_d, crc_byte;
    logic           tx_en_q, tx_en_d, tx_er_q, tx_er_d;
    logic           busy_q, done_q, abort_q, abort_d;
    logic           fcs_end_q, fcs_end_d;
    logic           crc_en, crc_init;
    logic [10:0]    hdr_last, min_eff;

`ifdef MAC_VLAN_EN
    assign vlan_in = vlan_insert;
    assign hdr_in  = vlan_insert ?
        {des_mac_addr, src_mac_addr, 16'h8100, vlan_tag, prot_type} :
        {des_mac_addr, src_mac_addr, prot_type, 32'h0};
`else
    assign vlan_in = 1'b0;
    assign hdr_in  = {des_mac_addr, src_mac_addr, prot_type, 32'h0};
`endif

    assign hdr_last = vlan_q ? 11'd17 : 11'd13;
    assign min_eff  = vlan_q ? MIN_L - 11'd4 : MIN_L;
    assign cnt_nx   = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign fcs_w    = ~crc_q;

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? (r >> 1) ^ 32'hEDB88320 : (r >> 1);
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        vlan_d    = vlan_q;
        txd_d     = 8'h00;
        tx_en_d   = 1'b0;
        tx_er_d   = 1'b0;
        abort_d   = 1'b0;
        fcs_end_d = 1'b0;
        crc_en    = 1'b0;
        crc_init  = 1'b0;
        crc_byte  = 8'h00;
        s_if.s_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                crc_init = 1'b1;
                cnt_d    = '0;
                if (s_if.s_valid) begin
                    hdr_d   = hdr_in;
                    vlan_d  = vlan_in;
                    state_d = PRE;
                end
            end
            PRE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
                cnt_d   = cnt_nx;
                if (cnt_q == PRE_END) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end
            end
            SFD: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
                state_d = HDR;
            end
            HDR: begin
                // Header leaves MSB first out of a shift register
                txd_d    = hdr_q[143:136];
                tx_en_d  = 1'b1;
                crc_en   = 1'b1;
                crc_byte = hdr_q[143:136];
                hdr_d    = {hdr_q[135:0], 8'h00};
                cnt_d    = cnt_nx;
                if (cnt_q == hdr_last) begin
                    state_d = PAY;
                    cnt_d   = '0;
                end
            end
            PAY: begin
                s_if.s_ready = 1'b1;
                tx_en_d      = 1'b1;
                if (!s_if.s_valid || cnt_q >= MAX_L) begin
                    tx_er_d = 1'b1;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = (s_if.s_valid && s_if.s_last) ? GAP : DRAIN;
                end else begin
                    txd_d    = s_if.s_data;
                    crc_en   = 1'b1;
                    crc_byte = s_if.s_data;
                    cnt_d    = cnt_nx;
                    if (s_if.s_last) begin
                        if (cnt_nx < min_eff) begin
                            state_d = PAD;
                        end else begin
                            state_d = FCS;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            PAD: begin
                tx_en_d = 1'b1;
                crc_en  = 1'b1;
                cnt_d   = cnt_nx;
                if (cnt_nx >= min_eff) begin
                    state_d = FCS;
                    cnt_d   = '0;
                end
            end
            FCS: begin
                txd_d   = fcs_w[{cnt_q[1:0], 3'b000} +: 8];
                tx_en_d = 1'b1;
                cnt_d   = cnt_nx;
                if (cnt_q[1:0] == 2'd3) begin
                    fcs_end_d = 1'b1;
                    state_d   = GAP;
                    cnt_d     = '0;
                end
            end
            IFG: begin
                cnt_d = cnt_nx;
                if (cnt_q == IFG_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                s_if.s_ready = 1'b1;
                if (s_if.s_valid && s_if.s_last) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hdr_q     <= '0;
            vlan_q    <= 1'b0;
            crc_q     <= '1;
            txd_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            fcs_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            vlan_q    <= vlan_d;
            txd_q     <= txd_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            busy_q    <= (state_d != IDLE);
            abort_q   <= abort_d;
            fcs_end_q <= fcs_end_d;
            done_q    <= fcs_end_q;
            if (crc_init)
                crc_q <= '1;
            else if (crc_en)
                crc_q <= crc_step(crc_q, crc_byte);
        end
    end

    assign tx_en       = tx_en_q;
    assign txd         = txd_q;
    assign tx_er       = tx_er_q;
    assign tx_busy     = busy_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: directed frames against a scoreboard of expected GMII bytes,
// tx_en run lengths, inter-frame gaps and done/abort events.
module tb_mac_tx_framer;

    localparam int PRE  = 7;
    localparam int MINP = 46;
    localparam int MAXP = 1500;
    localparam int IFG  = 12;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0] d;
        logic       er;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] da, sa;
    logic [15:0] et;
`ifdef MAC_VLAN_EN
    logic        vin;
    logic [15:0] vtag;
`endif
    logic        tx_en, tx_er, tx_busy, frame_done, frame_abort;
    logic [7:0]  txd;

    mac_tx_framer_if sif();

    mac_tx_framer #(
        .PREAMBLE_LEN(PRE), .MIN_PAYLOAD(MINP),
        .MAX_PAYLOAD(MAXP), .IFG_BYTES(IFG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .des_mac_addr(da), .src_mac_addr(sa), .prot_type(et),
`ifdef MAC_VLAN_EN
        .vlan_insert(vin), .vlan_tag(vtag),
`endif
        .s_if(sif.slave),
        .tx_en(tx_en), .txd(txd), .tx_er(tx_er), .tx_busy(tx_busy),
        .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #4 clk = ~clk;

    exp_t exp_q[$];
    int   len_q[$];
    int   ev_q[$];
    int   gap_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = b[7-j];
        return r;
    endfunction

    // MSB-first CRC32 on bit-reversed bytes, then reflected and inverted
    function automatic logic [31:0] fcs_ref(input bq_t q);
        logic [31:0] c, r;
        c = 32'hFFFFFFFF;
        foreach (q[k]) begin
            c = c ^ {rev8(q[k]), 24'h0};
            for (int j = 0; j < 8; j++)
                c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        for (int j = 0; j < 32; j++) r[j] = c[31-j];
        return ~r;
    endfunction

    function automatic logic [7:0] pb(input int seed, input int i);
        return 8'(seed + i * 7);
    endfunction

    task automatic send_frame(input int len, input int seed, input int under_at,
                              input bit vlan, input logic [15:0] tag,
                              input logic [47:0] d_a, input logic [47:0] s_a,
                              input logic [15:0] e_t);
        bq_t         cov;
        int          hl, mine, abort_at, n, i, cyc;
        bit          dropped, acc;
        logic [31:0] f;
        exp_t        e;
        da = d_a; sa = s_a; et = e_t;
`ifdef MAC_VLAN_EN
        vin = vlan; vtag = tag;
`endif
        hl = vlan ? 18 : 14;
        mine = vlan ? MINP - 4 : MINP;
        abort_at = (under_at >= 0) ? under_at : ((len > MAXP) ? MAXP : -1);
        for (int k = 0; k < PRE; k++) begin
            e.d = 8'h55; e.er = 1'b0; exp_q.push_back(e);
        end
        e.d = 8'hD5; exp_q.push_back(e);
        for (int k = 0; k < 6; k++) cov.push_back(d_a[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) cov.push_back(s_a[47-8*k -: 8]);
        if (vlan) begin
            cov.push_back(8'h81); cov.push_back(8'h00);
            cov.push_back(tag[15:8]); cov.push_back(tag[7:0]);
        end
        cov.push_back(e_t[15:8]); cov.push_back(e_t[7:0]);
        n = (abort_at >= 0) ? abort_at : len;
        for (int k = 0; k < n; k++) cov.push_back(pb(seed, k));
        if (abort_at < 0)
            for (int k = len; k < mine; k++) cov.push_back(8'h00);
        foreach (cov[k]) begin
            e.d = cov[k]; e.er = 1'b0; exp_q.push_back(e);
        end
        if (abort_at >= 0) begin
            e.d = 8'h00; e.er = 1'b1; exp_q.push_back(e);
            len_q.push_back(PRE + 1 + hl + abort_at + 1);
            ev_q.push_back(2);
        end else begin
            f = fcs_ref(cov);
            for (int k = 0; k < 4; k++) begin
                e.d = f[8*k +: 8]; e.er = 1'b0; exp_q.push_back(e);
            end
            len_q.push_back(PRE + 1 + cov.size() + 4);
            ev_q.push_back(1);
        end
        i = 0; cyc = 0; dropped = 1'b0;
        while (i < len) begin
            @(negedge clk);
            sif.s_data  = pb(seed, i);
            sif.s_last  = (i == len - 1);
            sif.s_valid = 1'b1;
            if (i == under_at && !dropped && sif.s_ready) begin
                sif.s_valid = 1'b0;
                dropped = 1'b1;
            end
            acc = sif.s_valid && sif.s_ready;
            @(posedge clk);
            if (acc) i++;
            cyc++;
            if (cyc > len + 400) begin
                check("send_timeout", i, len);
                break;
            end
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((tx_busy || exp_q.size() > 0) && n < 4000);
        check("idle_reached", int'(tx_busy), 0);
        check("bytes_drained", exp_q.size(), 0);
        check("events_drained", ev_q.size(), 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a byte or event
    initial begin
        exp_t e;
        int   hirun = 0;
        int   lorun = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                hirun = 0;
                lorun = 0;
            end else begin
                if (tx_en) begin
                    if (lorun > 0 && gap_q.size() > 0)
                        check("ifg_gap", lorun, gap_q.pop_front());
                    lorun = 0;
                    hirun++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", int'(txd), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("txd", int'(txd), int'(e.d));
                        check("tx_er", int'(tx_er), int'(e.er));
                    end
                end else begin
                    if (hirun > 0 && len_q.size() > 0)
                        check("tx_en_len", hirun, len_q.pop_front());
                    hirun = 0;
                    lorun++;
                    check("tx_er_idle", int'(tx_er), 0);
                end
                if (frame_done) begin
                    if (ev_q.size() == 0) check("unexpected_done", 1, 0);
                    else check("event_done", 1, ev_q.pop_front());
                end
                if (frame_abort) begin
                    if (ev_q.size() == 0) check("unexpected_abort", 2, 0);
                    else check("event_abort", 2, ev_q.pop_front());
                end
            end
        end
    end

    initial begin
        bq_t t;
        sif.s_valid = 1'b0;
        sif.s_data  = 8'h00;
        sif.s_last  = 1'b0;
        da = '0; sa = '0; et = '0;
`ifdef MAC_VLAN_EN
        vin = 1'b0; vtag = '0;
`endif
        t = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("crc_model", fcs_ref(t), 32'hCBF43926);

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_en", int'(tx_en), 0);
        check("rst_txd", int'(txd), 0);
        check("rst_tx_er", int'(tx_er), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_abort", int'(frame_abort), 0);
        check("rst_ready", int'(sif.s_ready), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1 nominal 64-byte payload
        send_frame(64, 1, -1, 0, 16'h0, 48'h001122334455, 48'hA0B1C2D3E4F5, 16'h0800);
        drop_valid(); wait_idle();
        // T2 short payload padded to 46
        send_frame(10, 9, -1, 0, 16'h0, 48'hFFFFFFFFFFFF, 48'h021A2B3C4D5E, 16'h0806);
        drop_valid(); wait_idle();
        // Pad boundaries
        send_frame(46, 3, -1, 0, 16'h0, 48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0800);
        drop_valid(); wait_idle();
        send_frame(45, 4, -1, 0, 16'h0, 48'h0A0B0C0D0E0F, 48'h102030405060, 16'h86DD);
        drop_valid(); wait_idle();
        send_frame(1, 5, -1, 0, 16'h0, 48'h123456789ABC, 48'hCBA987654321, 16'h0800);
        drop_valid(); wait_idle();
        // T3 underrun after 20 bytes
        send_frame(40, 6, 20, 0, 16'h0, 48'h001122334455, 48'hA0B1C2D3E4F5, 16'h0800);
        drop_valid(); wait_idle();
        // Largest legal payload
        send_frame(MAXP, 7, -1, 0, 16'h0, 48'h665544332211, 48'h0F0E0D0C0B0A, 16'h0800);
        drop_valid(); wait_idle();
        // T4 oversize: abort at byte 1501, drained to s_last
        send_frame(1600, 8, -1, 0, 16'h0, 48'h665544332211, 48'h0F0E0D0C0B0A, 16'h0800);
        drop_valid(); wait_idle();
        // T5 back-to-back, s_valid held high
        send_frame(50, 11, -1, 0, 16'h0, 48'h111111111111, 48'h222222222222, 16'h0800);
        gap_q.push_back(IFG);
        send_frame(47, 12, -1, 0, 16'h0, 48'h333333333333, 48'h444444444444, 16'h0801);
        drop_valid(); wait_idle();
        check("gap_consumed", gap_q.size(), 0);

        // T6 reset mid-payload, then a fresh frame
        mon_en = 1'b0;
        @(negedge clk);
        sif.s_valid = 1'b1; sif.s_data = 8'hAA; sif.s_last = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t6_midframe_tx_en", int'(tx_en), 1);
        #1;
        rst_n = 1'b0;
        sif.s_valid = 1'b0;
        exp_q.delete(); len_q.delete(); ev_q.delete(); gap_q.delete();
        #1;
        check("t6_tx_en", int'(tx_en), 0);
        check("t6_txd", int'(txd), 0);
        check("t6_tx_er", int'(tx_er), 0);
        check("t6_busy", int'(tx_busy), 0);
        check("t6_done", int'(frame_done), 0);
        check("t6_abort", int'(frame_abort), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(10, 13, -1, 0, 16'h0, 48'h00AABBCCDDEE, 48'h0155AA55AA55, 16'h0800);
        drop_valid(); wait_idle();

`ifdef MAC_VLAN_EN
        // T7 VLAN tag 0x0064 with 10-byte payload
        send_frame(10, 14, -1, 1, 16'h0064, 48'h001122334455, 48'hA0B1C2D3E4F5, 16'h0800);
        drop_valid(); wait_idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
